// File: rtl/chk_tx_fifo_seq.sv
// Stateful checker for the PCS TX FIFO read port: verifies filler codes in
// disabled slots and a running +STEP sequence across enabled slots.
module chk_tx_fifo_seq #(
    parameter int unsigned       W           = 12,
    parameter int unsigned       LANES       = 2,
    parameter int unsigned       STEP        = 8,
    parameter logic [W-1:0]      IDLE        = 12'h555,
    parameter logic [W-1:0]      SYNC        = 12'hAAA,
    parameter int unsigned       HEAD_W      = 4,
    parameter logic [HEAD_W-1:0] LANEOK_HEAD = 4'hB,
    parameter int unsigned       CNT_W       = 16,
    parameter int unsigned       RELOCK_N    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 pop,
    input  logic [LANES-1:0]     en_rd,
    input  logic [LANES*W-1:0]   data_rd,
    output logic                 correct,
    output logic                 locked,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     word_cnt,
    output logic [LANES*W-1:0]   first_err_data,
    output logic [LANES-1:0]     first_err_en
);

    localparam int unsigned PC_W  = $clog2(LANES + 1);
    localparam int unsigned BAD_W = $clog2(RELOCK_N + 1);

    typedef enum logic {SEED, CHECK} state_t;

    state_t               r_state, w_state_nxt;
    logic [BAD_W-1:0]     r_bad, w_bad_nxt, w_bad_inc;
    logic [W-1:0]         r_last;
    logic                 r_correct, r_sticky;
    logic [CNT_W-1:0]     r_err_cnt, r_word_cnt;
    logic [LANES*W-1:0]   r_fe_data;
    logic [LANES-1:0]     r_fe_en;

    logic                 w_fill_ok, w_seq_ok, w_have, w_good;
    logic [W-1:0]         w_prev, w_slot;
    logic [PC_W-1:0]      w_pc, w_add;
    logic [CNT_W:0]       w_wsum;

    // w_prev ends holding the highest-index enabled slot (next value of last)
    always_comb begin
        w_fill_ok = 1'b1;
        w_seq_ok  = 1'b1;
        w_have    = 1'b0;
        w_prev    = r_last;
        w_pc      = '0;
        w_slot    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_slot = data_rd[i*W +: W];
            if (en_rd[i]) begin
                w_pc = w_pc + PC_W'(1);
                if ((w_have || r_state == CHECK) && (w_slot != w_prev + W'(STEP)))
                    w_seq_ok = 1'b0;
                w_prev = w_slot;
                w_have = 1'b1;
            end else if (!(w_slot == IDLE || w_slot == SYNC ||
                           w_slot[W-1 -: HEAD_W] == LANEOK_HEAD)) begin
                w_fill_ok = 1'b0;
            end
        end
        w_good = w_fill_ok && w_seq_ok;
        w_add  = pop ? w_pc : '0;
        w_wsum = {1'b0, r_word_cnt} + (CNT_W+1)'(w_add);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bad_nxt   = r_bad;
        w_bad_inc   = r_bad + BAD_W'(1);
        if (pop) begin
            case (r_state)
                SEED: begin
                    if (w_good && (|en_rd)) w_state_nxt = CHECK;
                    w_bad_nxt = '0;
                end
                CHECK: begin
                    if (w_good) begin
                        w_bad_nxt = '0;
                    end else if (w_bad_inc == BAD_W'(RELOCK_N)) begin
                        w_state_nxt = SEED;
                        w_bad_nxt   = '0;
                    end else begin
                        w_bad_nxt = w_bad_inc;
                    end
                end
                default: w_state_nxt = SEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_state    <= SEED;
            r_bad      <= '0;
            r_last     <= '0;
            r_correct  <= 1'b1;
            r_sticky   <= 1'b0;
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
            r_fe_data  <= '0;
            r_fe_en    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bad      <= w_bad_nxt;
            r_correct  <= pop ? w_good : 1'b1;
            r_word_cnt <= w_wsum[CNT_W] ? '1 : w_wsum[CNT_W-1:0];
            if (pop && (|en_rd))
                r_last <= w_prev;
            if (pop && !w_good) begin
                if (r_err_cnt != '1)
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                r_sticky <= 1'b1;
                if (!r_sticky) begin
                    r_fe_data <= data_rd;
                    r_fe_en   <= en_rd;
                end
            end
        end
    end

    assign correct        = r_correct;
    assign locked         = (r_state == CHECK);
    assign err_sticky     = r_sticky;
    assign err_cnt        = r_err_cnt;
    assign word_cnt       = r_word_cnt;
    assign first_err_data = r_fe_data;
    assign first_err_en   = r_fe_en;

endmodule

// File: doc/chk_tx_fifo_seq.md
Name: chk_tx_fifo_seq

Overview:
Parametrised, stateful checker for the PCS TX FIFO read port, used in the 25G PCS bench. Each popped word carries LANES slots of W bits. Enabled slots must continue a running +STEP sequence in ascending slot order. Disabled slots must hold filler codes (IDLE, SYNC, or a LANEOK header). The block adds sequence seeding/lock, automatic relock after repeated failures, error/word counters and first-error capture.

Parameters:
W, 12, slot width in bits
LANES, 2, slots per popped word; slot 0 occupies data_rd[W-1:0] and is earliest in the sequence
STEP, 8, required increment between consecutive valid slots, modulo 2^W
IDLE, 12'h555, filler code
SYNC, 12'hAAA, filler code
HEAD_W, 4, width of the LANEOK header field (slot MSBs)
LANEOK_HEAD, 4'hB, LANEOK header value
CNT_W, 16, counter width
RELOCK_N, 4, consecutive bad pops in CHECK that force a return to SEED

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
clear  in  1  synchronous clear of counters, sticky flag, capture and state
pop  in  1  read strobe; word valid this cycle
en_rd  in  LANES  per-slot valid mask
data_rd  in  LANES*W  popped word
correct  out  1  registered per-pop verdict
locked  out  1  high in CHECK state
err_sticky  out  1  set on first bad pop; held until clear or reset
err_cnt  out  CNT_W  bad-pop count, saturating
word_cnt  out  CNT_W  enabled-slot count, saturating
first_err_data  out  LANES*W  data_rd of the first bad pop
first_err_en  out  LANES  en_rd of the first bad pop

Behaviour:
- Reset (priority over everything):
  - state=SEED, correct=1, locked=0, err_sticky=0
  - err_cnt=0, word_cnt=0, first_err_*=0
  - last=0, consecutive-bad counter=0
- clear=1 with reset_n=1: same effect as reset. Any pop in that cycle is ignored.
- Per-pop evaluation, combinational in the cycle pop=1:
  - Filler check: every slot with en_rd[i]=0 must equal IDLE or SYNC, or have its top HEAD_W bits equal LANEOK_HEAD.
  - Sequence check: take the enabled slots in ascending index.
    - Each enabled slot after the first must equal the previous enabled slot + STEP (mod 2^W).
    - In CHECK, the first enabled slot must also equal last + STEP.
    - In SEED, the first enabled slot is unconstrained.
  - good = filler check AND sequence check.
- Outputs update on the clock edge after the pop (1-cycle latency):
  - correct <= good.
  - When pop=0, correct <= 1.
- Datapath registers:
  - last <= highest-index enabled slot, only when pop=1 and en_rd!=0. This happens whether or not the pop is good, so the checker tracks the stream after a glitch.
  - en_rd=0 pops apply only the filler check and leave last unchanged.
  - word_cnt += popcount(en_rd & {LANES{pop}}), saturating at 2^CNT_W-1.
- Error handling on a bad pop:
  - err_cnt += 1 (saturating).
  - err_sticky <= 1.
  - first_err_* is captured only if err_sticky was 0 before this pop.
- State machine:
  - SEED → CHECK on a good pop with en_rd!=0.
  - A bad pop or an en_rd=0 pop leaves the state in SEED.
  - CHECK: a bad pop increments the consecutive-bad counter; a good pop zeroes it.
  - CHECK → SEED when the consecutive-bad counter reaches RELOCK_N. The counter is zeroed on the transition.
  - locked = (state==CHECK), registered.
- Boundaries:
  - Sequence wrap from 2^W-STEP to 0 is valid.
  - A filler value in an enabled slot is judged only by the sequence check.
  - Counters hold at all-ones.

Test Plan:
- Seed and run: reset, then pops with en=11 carrying {0x010,0x008}, {0x020,0x018} → correct=1 on both, locked=1 from the cycle after the first pop, word_cnt=4, err_cnt=0.
- Partial masks: after last=0x020, pops with en=01 data {0x555,0x028}, then en=10 data {0x030,0xAAA}, then en=00 data {0xB12,0x555} → all correct=1, last=0x030.
- Wrap: last=0xFF8, en=11 data {0x008,0x000} → correct=1.
- Single glitch: in CHECK with last=0x030, pop en=01 data {0x555,0x040} → correct=0, err_cnt=1, err_sticky=1, first_err_data=0x555040. Next pop {0x555,0x048} → correct=1, locked stays 1.
- Relock: 4 consecutive bad pops → locked=0. The next good pop with en!=0 → locked=1. A further bad pop leaves first_err_* unchanged.
- Clear/reset mid-stream: clear=1 together with a bad pop → err_cnt=0, err_sticky=0, locked=0, correct=1. reset_n=0 asserted with clear=1 gives the same reset values.
